// File: rtl/mtimer_pkg.sv
// Shared register map, reset constants and byte-lane merge helper for the machine timer.
package mtimer_pkg;

    localparam logic [1:0] MTIME_LO_OFF    = 2'd0;
    localparam logic [1:0] MTIME_HI_OFF    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO_OFF = 2'd2;
    localparam logic [1:0] MTIMECMP_HI_OFF = 2'd3;

    localparam logic [63:0] MTIMECMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] MTIMER_BASE_ADDR = 32'h0200_4000;

    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the core clock into the mtime increment strobe: tick is high every PRESCALE-th cycle.
module mtimer_prescaler #(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mtimer_clint.sv
// Memory-mapped 64-bit mtime/mtimecmp with a registered level interrupt; single-cycle bus ack.
// MTIMER_SNAPSHOT_EN: a MTIME_LO read latches mtime[63:32] so the following MTIME_HI read is tear-free.
module mtimer_clint
    import mtimer_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        irq_mtimecmp
);

    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic        wr_en, rd_en, mtime_wr;
    logic [31:0] hi_rd_word, rd_word;

    mtimer_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (rd_en && bus_addr == MTIME_LO_OFF) shadow_d = mtime_q[63:32];
        hi_rd_word = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (reset) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end
`else
    always_comb hi_rd_word = mtime_q[63:32];
`endif

    always_comb begin
        wr_en    = bus_req & bus_we;
        rd_en    = bus_req & ~bus_we;
        mtime_wr = wr_en & ((bus_addr == MTIME_LO_OFF) | (bus_addr == MTIME_HI_OFF));

        // A software write to either half freezes the whole counter for that cycle.
        mtime_d = mtime_q;
        if (mtime_wr) begin
            if (bus_addr == MTIME_LO_OFF)
                mtime_d[31:0]  = apply_be(mtime_q[31:0], bus_wdata, bus_be);
            else
                mtime_d[63:32] = apply_be(mtime_q[63:32], bus_wdata, bus_be);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_en && bus_addr == MTIMECMP_LO_OFF)
            mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], bus_wdata, bus_be);
        if (wr_en && bus_addr == MTIMECMP_HI_OFF)
            mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], bus_wdata, bus_be);

        case (bus_addr)
            MTIME_LO_OFF:    rd_word = mtime_q[31:0];
            MTIME_HI_OFF:    rd_word = hi_rd_word;
            MTIMECMP_LO_OFF: rd_word = mtimecmp_q[31:0];
            default:         rd_word = mtimecmp_q[63:32];
        endcase

        rdata_d = rd_en ? rd_word : '0;
        ack_d   = bus_req;
        irq_d   = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    assign bus_rdata    = rdata_q;
    assign bus_ack      = ack_q;
    assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// Directed bench for mtimer_clint: one PRESCALE=1 and one PRESCALE=4 instance on a shared, steered bus.
module tb_mtimer_clint;
    import mtimer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sel, bus_req, bus_we;
    logic [1:0]  bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        req1, req4;
    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, irq1, irq4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    assign req1 = bus_req & ~sel;
    assign req4 = bus_req & sel;

    always #5 clk = ~clk;

    // Posedges since reset release; the PRESCALE=4 instance ticks on the posedge that makes cyc a multiple of 4.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    mtimer_clint #(.PRESCALE(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .bus_req(req1), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(rdata1), .bus_ack(ack1),
        .irq_mtimecmp(irq1)
    );

    mtimer_clint #(.PRESCALE(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .reset(reset), .bus_req(req4), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(rdata4), .bus_ack(ack4),
        .irq_mtimecmp(irq4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic s, input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        sel = s; bus_addr = a; bus_we = 1'b0; bus_be = 4'h0; bus_wdata = '0; bus_req = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus_req = 1'b0;
        chk({tag, "_ack"}, 32'(s ? ack4 : ack1), 32'd1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, s ? rdata4 : rdata1, e);
    endtask

    task automatic wr(input logic s, input logic [1:0] a, input logic [3:0] be,
                      input logic [31:0] d, input string tag);
        sel = s; bus_addr = a; bus_we = 1'b1; bus_be = be; bus_wdata = d; bus_req = 1'b1;
        @(negedge clk);
        bus_req = 1'b0;
        chk({tag, "_ack"}, 32'(s ? ack4 : ack1), 32'd1);
    endtask

    // Stop at the negedge whose following posedge has (cyc+1)%4 == ph.
    task automatic align(input int ph);
        int n = 0;
        while (((cyc + 1) % 4) != ph && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("align", 32'(((cyc + 1) % 4) == ph), 32'd1);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_be = '0; bus_wdata = '0;
        idle(3);
        chk("rst_ack1",   32'(ack1), 32'd0);
        chk("rst_rdata1", rdata1,    32'd0);
        chk("rst_irq1",   32'(irq1), 32'd0);
        chk("rst_irq4",   32'(irq4), 32'd0);
        reset = 1'b0;

        // PRESCALE=1 free run: 10 posedges after release mtime is 10.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_irq1", 32'(irq1), 32'd0);
        end
        rd(1'b0, MTIME_LO_OFF, 32'd10, "p1_lo");
        rd(1'b0, MTIME_HI_OFF, 32'd0,  "p1_hi");

        // Compare/interrupt on the PRESCALE=1 instance.
        wr(1'b0, MTIMECMP_HI_OFF, 4'hF, 32'd0,   "cmp_hi0");
        wr(1'b0, MTIME_LO_OFF,    4'hF, 32'd90,  "mt90");
        wr(1'b0, MTIMECMP_LO_OFF, 4'hF, 32'd100, "cmp100");
        idle(9);
        chk("irq_before", 32'(irq1), 32'd0);
        idle(1);
        chk("irq_rise",   32'(irq1), 32'd1);
        wr(1'b0, MTIMECMP_LO_OFF, 4'hF, 32'd500, "cmp500");
        chk("irq_at_ack", 32'(irq1), 32'd1);
        idle(1);
        chk("irq_drop",   32'(irq1), 32'd0);

        // Byte-lane write into the reset value of MTIMECMP_LO.
        wr(1'b1, MTIMECMP_LO_OFF, 4'b0010, 32'h0000_AB00, "be_wr");
        rd(1'b1, MTIMECMP_LO_OFF, 32'hFFFF_ABFF, "be_lo");
        rd(1'b1, MTIMECMP_HI_OFF, 32'hFFFF_FFFF, "be_hi");
        chk("irq4_low", 32'(irq4), 32'd0);

        // PRESCALE=4: write lands just after a tick; next ticks at W+3, W+7, W+11, W+15.
        align(1);
        wr(1'b1, MTIME_LO_OFF, 4'hF, 32'd0, "p4_clr");
        rd(1'b1, MTIME_LO_OFF, 32'd0, "p4_w1");
        rd(1'b1, MTIME_LO_OFF, 32'd0, "p4_w2");
        rd(1'b1, MTIME_LO_OFF, 32'd0, "p4_w3");
        rd(1'b1, MTIME_LO_OFF, 32'd1, "p4_w4");
        idle(12);
        rd(1'b1, MTIME_LO_OFF, 32'd4, "p4_w17");

        // Write on a tick edge suppresses the increment; a mtimecmp write does not.
        align(0);
        wr(1'b1, MTIME_LO_OFF, 4'hF, 32'h0000_1234, "tick_wr");
        rd(1'b1, MTIME_LO_OFF, 32'h0000_1234, "tick_wr_rd");
        align(0);
        wr(1'b1, MTIMECMP_LO_OFF, 4'hF, 32'h0000_0050, "tick_cmp_wr");
        rd(1'b1, MTIME_LO_OFF, 32'h0000_1235, "tick_cmp_rd");

        // Carry from lo into hi.
        wr(1'b1, MTIME_HI_OFF, 4'hF, 32'd0, "cy_hi");
        align(1);
        wr(1'b1, MTIME_LO_OFF, 4'hF, 32'hFFFF_FFFF, "cy_lo");
        rd(1'b1, MTIME_LO_OFF, 32'hFFFF_FFFF, "cy_lo_pre");
        rd(1'b1, MTIME_HI_OFF, 32'd0,         "cy_hi_pre");
        idle(1);
        rd(1'b1, MTIME_LO_OFF, 32'd0, "cy_lo_post");
        rd(1'b1, MTIME_HI_OFF, 32'd1, "cy_hi_post");

        // LO read, carry in between, then HI read.
        wr(1'b1, MTIME_HI_OFF, 4'hF, 32'd1, "sn_hi");
        align(1);
        wr(1'b1, MTIME_LO_OFF, 4'hF, 32'hFFFF_FFFF, "sn_lo");
        rd(1'b1, MTIME_LO_OFF, 32'hFFFF_FFFF, "sn_lo_rd");
        idle(2);
`ifdef MTIMER_SNAPSHOT_EN
        rd(1'b1, MTIME_HI_OFF, 32'd1, "sn_hi_shadow");
`else
        rd(1'b1, MTIME_HI_OFF, 32'd2, "sn_hi_live");
`endif

        // Raise irq, then assert reset during an access: no ack, outputs cleared.
        wr(1'b0, MTIMECMP_LO_OFF, 4'hF, 32'd0, "cmp0");
        idle(1);
        chk("irq_pre_rst", 32'(irq1), 32'd1);
        sel = 1'b0; bus_addr = MTIME_LO_OFF; bus_we = 1'b0; bus_req = 1'b1; reset = 1'b1;
        @(negedge clk);
        bus_req = 1'b0;
        chk("rst_mid_ack",   32'(ack1), 32'd0);
        chk("rst_mid_rdata", rdata1,    32'd0);
        chk("rst_mid_irq",   32'(irq1), 32'd0);
        reset = 1'b0;
        rd(1'b0, MTIME_LO_OFF,    32'd0,         "post_rst_lo");
        rd(1'b0, MTIMECMP_LO_OFF, 32'hFFFF_FFFF, "post_rst_cmp");
        idle(1);
        chk("idle_ack", 32'(ack1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
